// File: rtl/life_sequencer.sv
// Generation sequencer for the 8x8 Game-of-Life grid: seed load, paced/stepped commits, halt detection.
// Define LIFE_SEQ_OSC_DETECT_EN to add period-2 oscillation detection (osc output and prev-grid storage).
module life_sequencer #(
  parameter int DIV_W = 24,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [63:0]      grid_next,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic [1:0]       state,
  output logic             extinct,
  output logic             still,
  output logic             osc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAUSE = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [63:0]      grid_reg;
  logic [GEN_W-1:0] gen_count_reg;
  logic [DIV_W-1:0] tick_reg;
  logic             step_q_reg;
  logic             extinct_reg;
  logic             still_reg;

  logic             step_edge;
  logic             commit;
  logic             is_extinct;
  logic             is_still;
  logic             osc_hit;
  logic             halt_hit;
  logic [GEN_W-1:0] gen_count_next;

  assign step_edge  = step & ~step_q_reg;
  // A run request in PAUSE wins over a coincident step edge, so the step never commits.
  assign commit     = ((state_reg == S_PAUSE) && !run && step_edge) ||
                      ((state_reg == S_RUN) && run && (tick_reg == div));
  assign is_extinct = (grid_next == 64'd0);
  assign is_still   = (grid_next == grid_reg);
  assign halt_hit   = is_extinct | is_still | osc_hit;
  assign gen_count_next = (gen_count_reg == {GEN_W{1'b1}}) ? gen_count_reg
                                                           : gen_count_reg + GEN_W'(1);

`ifdef LIFE_SEQ_OSC_DETECT_EN
  logic [63:0] prev_grid_reg;
  logic        prev_valid_reg;
  logic        osc_reg;

  // A change that returns to the generation before last is a period-2 oscillator.
  assign osc_hit = prev_valid_reg && (grid_next == prev_grid_reg) && !is_still;
  assign osc     = osc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_grid_reg  <= 64'd0;
      prev_valid_reg <= 1'b0;
      osc_reg        <= 1'b0;
    end else if (load) begin
      prev_valid_reg <= 1'b0;
      osc_reg        <= 1'b0;
    end else if (commit) begin
      prev_grid_reg  <= grid_reg;
      prev_valid_reg <= 1'b1;
      osc_reg        <= osc_hit;
    end
  end
`else
  assign osc_hit = 1'b0;
  assign osc     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      grid_reg      <= 64'd0;
      gen_count_reg <= '0;
      tick_reg      <= '0;
      step_q_reg    <= 1'b0;
      extinct_reg   <= 1'b0;
      still_reg     <= 1'b0;
    end else begin
      step_q_reg <= step;
      if (load) begin
        state_reg     <= S_PAUSE;
        grid_reg      <= seed;
        gen_count_reg <= '0;
        tick_reg      <= '0;
        extinct_reg   <= 1'b0;
        still_reg     <= 1'b0;
      end else begin
        if (commit) begin
          grid_reg      <= grid_next;
          gen_count_reg <= gen_count_next;
          extinct_reg   <= is_extinct;
          still_reg     <= is_still;
        end
        case (state_reg)
          S_PAUSE: begin
            if (run) begin
              state_reg <= S_RUN;
              tick_reg  <= '0;
            end else if (commit && halt_hit) begin
              state_reg <= S_HALT;
            end
          end
          S_RUN: begin
            if (!run) begin
              state_reg <= S_PAUSE;
              tick_reg  <= '0;
            end else if (commit) begin
              tick_reg <= '0;
              if (halt_hit) state_reg <= S_HALT;
            end else begin
              // A tick already past a newly lowered div wraps through the full range.
              tick_reg <= tick_reg + DIV_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign grid      = grid_reg;
  assign gen_count = gen_count_reg;
  assign state     = state_reg;
  assign extinct   = extinct_reg;
  assign still     = still_reg;

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: includes a Life evolve function as the datapath and a cycle model of the rules.
module tb_life_sequencer;

  localparam int DIV_W = 24;
  localparam int GEN_W = 16;

  logic             clk;
  logic             reset;
  logic [63:0]      seed;
  logic             load;
  logic             run;
  logic             step;
  logic [DIV_W-1:0] div;
  logic [63:0]      grid_next;
  logic [63:0]      grid;
  logic [GEN_W-1:0] gen_count;
  logic [1:0]       state;
  logic             extinct;
  logic             still;
  logic             osc;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 0;

  localparam logic [63:0] SEED1 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK = 64'h0000_0018_1800_0000;

  life_sequencer #(.DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .div(div), .grid_next(grid_next), .grid(grid), .gen_count(gen_count),
    .state(state), .extinct(extinct), .still(still), .osc(osc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounded (non-wrapping) Life rule: B3/S23.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign grid_next = life(grid);

  // Reference model of the sequencing rules.
  logic [63:0] m_grid, m_prev, m_nx;
  int          m_gen, m_state, m_tick;
  bit          m_ext, m_still, m_osc, m_pv, m_stepq;
  bit          m_commit, m_osc_hit, m_halt;

  assign m_nx = life(m_grid);
`ifdef LIFE_SEQ_OSC_DETECT_EN
  assign m_osc_hit = m_pv && (m_nx == m_prev) && (m_nx != m_grid);
`else
  assign m_osc_hit = 1'b0;
`endif
  assign m_halt   = (m_nx == 64'd0) || (m_nx == m_grid) || m_osc_hit;
  assign m_commit = (m_state == 1 && !run && step && !m_stepq) ||
                    (m_state == 2 && run && m_tick == int'(div));

  always @(posedge clk) begin
    m_stepq <= reset ? 1'b0 : step;
    if (reset) begin
      m_grid <= 64'd0; m_prev <= 64'd0; m_gen <= 0; m_state <= 0; m_tick <= 0;
      m_ext <= 0; m_still <= 0; m_osc <= 0; m_pv <= 0;
    end else if (load) begin
      m_grid <= seed; m_gen <= 0; m_state <= 1; m_tick <= 0;
      m_ext <= 0; m_still <= 0; m_osc <= 0; m_pv <= 0;
    end else begin
      if (m_commit) begin
        m_grid  <= m_nx;
        m_gen   <= (m_gen == (1 << GEN_W) - 1) ? m_gen : m_gen + 1;
        m_ext   <= (m_nx == 64'd0);
        m_still <= (m_nx == m_grid);
        m_osc   <= m_osc_hit;
        m_prev  <= m_grid;
        m_pv    <= 1;
      end
      if (m_state == 1) begin
        if (run) begin m_state <= 2; m_tick <= 0; end
        else if (m_commit && m_halt) m_state <= 3;
      end else if (m_state == 2) begin
        if (!run) begin m_state <= 1; m_tick <= 0; end
        else if (m_commit) begin m_tick <= 0; if (m_halt) m_state <= 3; end
        else m_tick <= (m_tick + 1) % (1 << DIV_W);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model grid", grid, m_grid);
      chk("model gen_count", 64'(gen_count), 64'(m_gen));
      chk("model state", 64'(state), 64'(m_state));
      chk("model extinct", 64'(extinct), 64'(m_ext));
      chk("model still", 64'(still), 64'(m_still));
      chk("model osc", 64'(osc), 64'(m_osc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] s);
    seed = s; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; seed = 64'd0; load = 1'b0; run = 1'b0; step = 1'b0; div = '0;
    cyc();
    cmp_en = 1;
    cyc();
    reset = 1'b0;
    chk("reset grid", grid, 64'd0);
    chk("reset state", 64'(state), 64'd0);
    chk("reset gen", 64'(gen_count), 64'd0);
    $display("reset: grid=%h state=%0d", grid, state);

    run = 1'b1; step = 1'b1;
    cyc();
    chk("idle ignores run/step", 64'(state), 64'd0);
    run = 1'b0; step = 1'b0;
    cyc();

    do_load(SEED1);
    chk("load grid", grid, SEED1);
    chk("load state", 64'(state), 64'd1);
    chk("load gen", 64'(gen_count), 64'd0);
    $display("load: grid=%h state=%0d gen=%0d", grid, state, gen_count);

    do_load(BLINK_H);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step grid", grid, BLINK_V);
    chk("step gen", 64'(gen_count), 64'd1);
    chk("step state", 64'(state), 64'd1);
    $display("step: grid=%h gen=%0d", grid, gen_count);
    cyc();
    step = 1'b1;
    repeat (10) cyc();
    step = 1'b0;
    chk("held step one commit", 64'(gen_count), 64'd2);
    chk("held step grid", grid, BLINK_H);
    $display("held step: gen=%0d", gen_count);
    cyc();

    do_load(BLINK_H);
    div = 24'd3; run = 1'b1;
    cyc();
    chk("run entry state", 64'(state), 64'd2);
    repeat (3) cyc();
    chk("run before first commit", 64'(gen_count), 64'd0);
    cyc();
    chk("run first commit @4", 64'(gen_count), 64'd1);
    repeat (4) cyc();
    chk("run second commit @8", 64'(gen_count), 64'd2);
    cyc();
    run = 1'b0;
    cyc();
    chk("run stop state", 64'(state), 64'd1);
    chk("run stop gen", 64'(gen_count), 64'd2);
    $display("div=3 run: stop state=%0d gen=%0d", state, gen_count);

    do_load(BLOCK);
    div = '0; run = 1'b1;
    repeat (2) cyc();
    chk("block still", 64'(still), 64'd1);
    chk("block state", 64'(state), 64'd3);
    chk("block gen", 64'(gen_count), 64'd1);
    run = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0; run = 1'b1;
    repeat (3) cyc();
    chk("halt frozen gen", 64'(gen_count), 64'd1);
    chk("halt frozen state", 64'(state), 64'd3);
    run = 1'b0;
    do_load(BLOCK);
    chk("halt load recover", 64'(state), 64'd1);
    chk("halt load clears still", 64'(still), 64'd0);
    $display("block: halted then reloaded state=%0d", state);

    do_load(64'h1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("single grid", grid, 64'd0);
    chk("single extinct", 64'(extinct), 64'd1);
    chk("single still", 64'(still), 64'd0);
    chk("single state", 64'(state), 64'd3);
    $display("single cell: extinct=%0d state=%0d", extinct, state);

    do_load(BLINK_H);
    div = '0; run = 1'b1;
    cyc();
`ifdef LIFE_SEQ_OSC_DETECT_EN
    repeat (2) cyc();
    chk("osc flag", 64'(osc), 64'd1);
    chk("osc state", 64'(state), 64'd3);
    chk("osc gen", 64'(gen_count), 64'd2);
`else
    repeat (20) cyc();
    chk("blinker still running", 64'(state), 64'd2);
    chk("blinker gen 20", 64'(gen_count), 64'd20);
    chk("blinker osc 0", 64'(osc), 64'd0);
`endif
    $display("blinker run: state=%0d gen=%0d osc=%0d", state, gen_count, osc);
    do_load(BLINK_H);
    chk("mid-run load gen", 64'(gen_count), 64'd0);
    chk("mid-run load state", 64'(state), 64'd1);

    div = 24'd2;
    repeat (7) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run = 1'b0;
    chk("mid-run reset state", 64'(state), 64'd0);
    chk("mid-run reset grid", grid, 64'd0);
    chk("mid-run reset gen", 64'(gen_count), 64'd0);
    $display("reset mid-run: state=%0d gen=%0d", state, gen_count);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
